watch_timekeeper: RTL and testbench

Time-of-day and stopwatch counting core of the wrist watch. It divides the system clock to a 1 Hz tick and maintains the 24-hour clock and the stopwatch. It applies set/run/clear commands according to the mode code from watch_fsm. Its six 6-bit binary counters and the `second` blink flag feed Seg7Display directly.

---
 rtl/watch_timekeeper.sv | 180 ++++++++++++++++++
 tb/tb_watch_timekeeper.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/watch_timekeeper.sv
// Watch timekeeping core: 1 Hz prescaler, 24-hour time of day, stopwatch with optional lap snapshot.
// Optional feature macro: WATCH_SW_LAP_EN (lap snapshot register and SW_LAP display hold).
module watch_timekeeper #(
  parameter int unsigned CLK_HZ = 32768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       btn_inc,
  input  logic       btn_clear,
  output logic [5:0] current_s,
  output logic [5:0] current_m,
  output logic [5:0] current_h,
  output logic [5:0] stopwatch_s,
  output logic [5:0] stopwatch_m,
  output logic [5:0] stopwatch_h,
  output logic       second
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  typedef enum logic [2:0] {
    M_TIME     = 3'd0,
    M_SET_HOUR = 3'd1,
    M_SET_MIN  = 3'd2,
    M_SW_IDLE  = 3'd3,
    M_SW_RUN   = 3'd4,
    M_SW_LAP   = 3'd5
  } mode_e;

  mode_e          mode;
  logic           tick;
  logic           run_set;
  logic [PW-1:0]  pre_q, pre_d;
  logic [5:0]     cs_q, cs_d, cm_q, cm_d, ch_q, ch_d;
  logic [5:0]     ss_q, ss_d, sm_q, sm_d, sh_q, sh_d;
  logic           run_q, run_d;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
    return (v == lim) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    case (state)
      3'd1:    mode = M_SET_HOUR;
      3'd2:    mode = M_SET_MIN;
      3'd3:    mode = M_SW_IDLE;
      3'd4:    mode = M_SW_RUN;
      3'd5:    mode = M_SW_LAP;
      default: mode = M_TIME;
    endcase
  end

  assign tick   = (pre_q == PRE_MAX);
  assign second = (pre_q < PRE_HALF);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    cs_d  = cs_q;
    cm_d  = cm_q;
    ch_d  = ch_q;
    case (mode)
      M_SET_HOUR: if (btn_inc) ch_d = inc_wrap(ch_q, 6'd23);
      M_SET_MIN: begin
        // Minute bump also realigns the second boundary.
        if (btn_inc) begin
          cm_d  = inc_wrap(cm_q, 6'd59);
          cs_d  = '0;
          pre_d = '0;
        end
      end
      default: begin
        if (tick) begin
          cs_d = inc_wrap(cs_q, 6'd59);
          if (cs_q == 6'd59) begin
            cm_d = inc_wrap(cm_q, 6'd59);
            if (cm_q == 6'd59) ch_d = inc_wrap(ch_q, 6'd23);
          end
        end
      end
    endcase
  end

  always_comb begin
    ss_d = ss_q;
    sm_d = sm_q;
    sh_d = sh_q;
    if (mode == M_SW_IDLE && btn_clear) begin
      ss_d = '0;
      sm_d = '0;
      sh_d = '0;
    end else if (tick && run_q) begin
      ss_d = inc_wrap(ss_q, 6'd59);
      if (ss_q == 6'd59) begin
        sm_d = inc_wrap(sm_q, 6'd59);
        if (sm_q == 6'd59) sh_d = inc_wrap(sh_q, 6'd59);
      end
    end
  end

`ifdef WATCH_SW_LAP_EN
  assign run_set = (mode == M_SW_RUN);
`else
  assign run_set = (mode == M_SW_RUN) || (mode == M_SW_LAP);
`endif

  always_comb begin
    run_d = run_q;
    if (run_set) run_d = 1'b1;
    else if (mode == M_SW_IDLE) run_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cs_q  <= '0;
      cm_q  <= '0;
      ch_q  <= '0;
      ss_q  <= '0;
      sm_q  <= '0;
      sh_q  <= '0;
      run_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cs_q  <= cs_d;
      cm_q  <= cm_d;
      ch_q  <= ch_d;
      ss_q  <= ss_d;
      sm_q  <= sm_d;
      sh_q  <= sh_d;
      run_q <= run_d;
    end
  end

  assign current_s = cs_q;
  assign current_m = cm_q;
  assign current_h = ch_q;

`ifdef WATCH_SW_LAP_EN
  mode_e      prev_q;
  logic [5:0] ls_q, ls_d, lm_q, lm_d, lh_q, lh_d;

  // Snapshot takes the pre-tick live value on the lap entry edge.
  always_comb begin
    ls_d = ls_q;
    lm_d = lm_q;
    lh_d = lh_q;
    if (mode == M_SW_LAP && prev_q != M_SW_LAP) begin
      ls_d = ss_q;
      lm_d = sm_q;
      lh_d = sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= M_TIME;
      ls_q   <= '0;
      lm_q   <= '0;
      lh_q   <= '0;
    end else begin
      prev_q <= mode;
      ls_q   <= ls_d;
      lm_q   <= lm_d;
      lh_q   <= lh_d;
    end
  end

  assign stopwatch_s = (mode == M_SW_LAP) ? ls_q : ss_q;
  assign stopwatch_m = (mode == M_SW_LAP) ? lm_q : sm_q;
  assign stopwatch_h = (mode == M_SW_LAP) ? lh_q : sh_q;
`else
  assign stopwatch_s = ss_q;
  assign stopwatch_m = sm_q;
  assign stopwatch_h = sh_q;
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper at CLK_HZ=4: directed table, hand sequences, random stimulus vs seconds-based model.
module tb_watch_timekeeper;
  localparam int HZ = 4;
`ifdef WATCH_SW_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'd0;
  logic       btn_inc = 1'b0;
  logic       btn_clear = 1'b0;
  logic [5:0] current_s, current_m, current_h;
  logic [5:0] stopwatch_s, stopwatch_m, stopwatch_h;
  logic       second;

  watch_timekeeper #(.CLK_HZ(HZ)) dut (
    .clk(clk), .reset(reset), .state(state), .btn_inc(btn_inc), .btn_clear(btn_clear),
    .current_s(current_s), .current_m(current_m), .current_h(current_h),
    .stopwatch_s(stopwatch_s), .stopwatch_m(stopwatch_m), .stopwatch_h(stopwatch_h),
    .second(second)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time of day and stopwatch as total seconds, phase as cycle within second.
  int m_tod = 0, m_sw = 0, m_snap = 0, m_phase = 0;
  bit m_run = 1'b0, m_prevlap = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input int st, input bit inc, input bit clr, input bit rst);
    int md, nph, h, m;
    bit tk;
    md = (st > 5) ? 0 : st;
    if (rst) begin
      m_tod = 0; m_sw = 0; m_snap = 0; m_phase = 0; m_run = 1'b0; m_prevlap = 1'b0;
      return;
    end
    tk  = (m_phase == HZ - 1);
    nph = (m_phase + 1) % HZ;
    if (md == 1) begin
      if (inc) begin
        h = m_tod / 3600;
        m_tod = ((h + 1) % 24) * 3600 + m_tod % 3600;
      end
    end else if (md == 2) begin
      if (inc) begin
        m = (m_tod / 60) % 60;
        m_tod = (m_tod / 3600) * 3600 + ((m + 1) % 60) * 60;
        nph = 0;
      end
    end else if (tk) begin
      m_tod = (m_tod + 1) % 86400;
    end
    if (LAP && md == 5 && !m_prevlap) m_snap = m_sw;
    if (md == 3 && clr) m_sw = 0;
    else if (tk && m_run) m_sw = (m_sw + 1) % 216000;
    if (md == 4 || (!LAP && md == 5)) m_run = 1'b1;
    else if (md == 3) m_run = 1'b0;
    m_prevlap = LAP && (md == 5);
    m_phase = nph;
  endfunction

  task automatic compare_model(input int st);
    int disp;
    disp = (LAP && st == 5) ? m_snap : m_sw;
    chk("model current_s", int'(current_s), m_tod % 60);
    chk("model current_m", int'(current_m), (m_tod / 60) % 60);
    chk("model current_h", int'(current_h), m_tod / 3600);
    chk("model stopwatch_s", int'(stopwatch_s), disp % 60);
    chk("model stopwatch_m", int'(stopwatch_m), (disp / 60) % 60);
    chk("model stopwatch_h", int'(stopwatch_h), disp / 3600);
    chk("model second", int'(second), (m_phase < HZ / 2) ? 1 : 0);
  endtask

  task automatic cyc(input logic [2:0] st, input logic inc, input logic clr, input logic rst);
    state = st; btn_inc = inc; btn_clear = clr; reset = rst;
    @(posedge clk);
    model_step(int'(st), inc, clr, rst);
    #1;
    compare_model(int'(st));
  endtask

  typedef struct {
    logic [2:0] st;
    logic       inc;
    logic       clr;
    int         n;
    int         s, m, h, sws;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];
  bit   exp_sec[4];

  initial begin
    tbl[0]  = '{3'd1, 1'b1, 1'b0, 28,  1,  0,  4,  0};
    tbl[1]  = '{3'd2, 1'b1, 1'b0, 61,  0,  1,  4,  0};
    tbl[2]  = '{3'd1, 1'b1, 1'b0, 19,  0,  1, 23,  0};
    tbl[3]  = '{3'd2, 1'b1, 1'b0, 58,  0, 59, 23,  0};
    tbl[4]  = '{3'd0, 1'b0, 1'b0, 236, 59, 59, 23, 0};
    tbl[5]  = '{3'd0, 1'b0, 1'b0, 4,   0,  0,  0,  0};
    tbl[6]  = '{3'd0, 1'b0, 1'b0, 3,   0,  0,  0,  0};
    tbl[7]  = '{3'd4, 1'b0, 1'b0, 12,  3,  0,  0,  2};
    tbl[8]  = '{3'd0, 1'b0, 1'b0, 8,   5,  0,  0,  4};
    tbl[9]  = '{3'd3, 1'b0, 1'b0, 1,   6,  0,  0,  5};
    tbl[10] = '{3'd3, 1'b0, 1'b0, 8,   8,  0,  0,  5};
    tbl[11] = '{3'd3, 1'b0, 1'b1, 1,   8,  0,  0,  0};
    tbl[12] = '{3'd4, 1'b0, 1'b0, 7,   10, 0,  0,  2};
    tbl[13] = '{3'd4, 1'b0, 1'b1, 1,   10, 0,  0,  2};
    tbl[14] = '{3'd0, 1'b0, 1'b1, 1,   10, 0,  0,  2};
    tbl[15] = '{3'd5, 1'b0, 1'b0, 8,   12, 0,  0,  LAP ? 2 : 4};
    tbl[16] = '{3'd4, 1'b0, 1'b0, 1,   12, 0,  0,  4};
    tbl[17] = '{3'd3, 1'b0, 1'b1, 1,   13, 0,  0,  0};
    tbl[18] = '{3'd0, 1'b0, 1'b0, 3,   13, 0,  0,  0};
    tbl[19] = '{3'd2, 1'b1, 1'b0, 1,   0,  1,  0,  0};
    tbl[20] = '{3'd0, 1'b0, 1'b0, 3,   0,  1,  0,  0};
    tbl[21] = '{3'd0, 1'b0, 1'b0, 1,   1,  1,  0,  0};
    exp_sec = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset held two cycles: everything zero, blink flag high.
    cyc(3'd0, 1'b0, 1'b0, 1'b1);
    cyc(3'd0, 1'b0, 1'b0, 1'b1);
    chk("reset current_s", int'(current_s), 0);
    chk("reset current_m", int'(current_m), 0);
    chk("reset current_h", int'(current_h), 0);
    chk("reset stopwatch_s", int'(stopwatch_s), 0);
    chk("reset stopwatch_m", int'(stopwatch_m), 0);
    chk("reset stopwatch_h", int'(stopwatch_h), 0);
    chk("reset second", int'(second), 1);

    // First tick lands on edge CLK_HZ; blink flag follows the prescaler.
    for (int i = 0; i < 4; i++) begin
      chk("first tick current_s pre", int'(current_s), 0);
      cyc(3'd0, 1'b0, 1'b0, 1'b0);
      chk("second pattern", int'(second), int'(exp_sec[i]));
    end
    chk("first tick current_s", int'(current_s), 1);

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < tbl[v].n; k++) cyc(tbl[v].st, tbl[v].inc, tbl[v].clr, 1'b0);
      chk($sformatf("vec%0d current_s", v), int'(current_s), tbl[v].s);
      chk($sformatf("vec%0d current_m", v), int'(current_m), tbl[v].m);
      chk($sformatf("vec%0d current_h", v), int'(current_h), tbl[v].h);
      chk($sformatf("vec%0d stopwatch_s", v), int'(stopwatch_s), tbl[v].sws);
    end

    // Reset mid-run overrides active inputs.
    cyc(3'd2, 1'b1, 1'b1, 1'b1);
    chk("reset override current_m", int'(current_m), 0);
    chk("reset override stopwatch_s", int'(stopwatch_s), 0);
    chk("reset override second", int'(second), 1);

    for (int r = 0; r < 300; r++) begin
      logic [2:0] st;
      int len;
      st  = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        cyc(st, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
